// File: rtl/etf_flow_analyzer.sv
// rtl/etf_flow_analyzer.sv - shift-add AUM multiplier and flow-vs-AUM basis-point alert with valid/ready result
// Optional record/alert counters: define ETF_FLOW_STATS_EN.
module etf_flow_analyzer #(
  parameter int unsigned THRESH_BPS = 50,
  parameter int unsigned MUL_CYCLES = 32
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] shares_outstanding,
  input  logic [31:0] nav,
  input  logic [31:0] flow_daily,
  input  logic        valid_in,
  output logic        busy,
  output logic [63:0] aum,
  output logic        alert,
  output logic        out_valid,
  input  logic        out_ready,
`ifdef ETF_FLOW_STATS_EN
  output logic [15:0] rec_count,
  output logic [15:0] alert_count,
`endif
  output logic [7:0]  overrun_cnt
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_CMP  = 2'd2;
  localparam logic [1:0] S_OUT  = 2'd3;

  logic [1:0]  state;
  logic        valid_in_q;
  logic        start;
  logic [63:0] mcand;
  logic [31:0] mplr;
  logic [31:0] flow_reg;
  logic [63:0] acc;
  logic [4:0]  cnt;
  logic [45:0] lhs;
  logic [77:0] rhs;

  assign start = valid_in & ~valid_in_q;

  // Full-width products so neither side of the threshold comparison can truncate.
  assign lhs = {14'b0, flow_reg} * 46'd10000;
  assign rhs = {14'b0, acc} * 78'(THRESH_BPS);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      valid_in_q  <= 1'b0;
      mcand       <= '0;
      mplr        <= '0;
      flow_reg    <= '0;
      acc         <= '0;
      cnt         <= '0;
      busy        <= 1'b0;
      aum         <= '0;
      alert       <= 1'b0;
      out_valid   <= 1'b0;
      overrun_cnt <= '0;
`ifdef ETF_FLOW_STATS_EN
      rec_count   <= '0;
      alert_count <= '0;
`endif
    end else begin
      valid_in_q <= valid_in;

      // A new record while one is in flight is dropped, never queued.
      if (start && state != S_IDLE && overrun_cnt != 8'hFF)
        overrun_cnt <= overrun_cnt + 8'd1;

      case (state)
        S_IDLE: begin
          if (start) begin
            mcand    <= {32'b0, shares_outstanding};
            mplr     <= nav;
            flow_reg <= flow_daily;
            acc      <= '0;
            cnt      <= 5'(MUL_CYCLES - 1);
            busy     <= 1'b1;
            state    <= S_MUL;
          end
        end
        S_MUL: begin
          if (mplr[0])
            acc <= acc + mcand;
          mplr  <= mplr >> 1;
          mcand <= mcand << 1;
          cnt   <= cnt - 5'd1;
          if (cnt == 5'd0)
            state <= S_CMP;
        end
        S_CMP: begin
          aum       <= acc;
          alert     <= ({32'b0, lhs} > rhs);
          out_valid <= 1'b1;
          state     <= S_OUT;
        end
        S_OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= S_IDLE;
`ifdef ETF_FLOW_STATS_EN
            rec_count <= rec_count + 16'd1;
            if (alert)
              alert_count <= alert_count + 16'd1;
`endif
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
